glb_2_lb: RTL and testbench
===========================

# glb_2_lb

Tile fetcher between the global buffer (GLB) and the line buffer (LB): on `start`, it reads an input-feature tile out of the GLB in row-major order and streams it into the LB over a valid/ready interface. It is the read-side counterpart of the LB-to-GLB writer and uses the same tile addressing: base address, page length, tile length and tile height. GLB read latency is fixed, so a small credit-controlled skid FIFO absorbs LB backpressure without losing in-flight reads.

## Interface
- `RD_LATENCY`, 1: GLB read latency in cycles from `rd_en` to valid `rd_data` (≥1).
- `FIFO_DEPTH`, 4: skid FIFO entries; must be ≥ `RD_LATENCY`+1.
- `clock` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `if_base_addr` in 16: GLB word address of tile element (0,0).
- `if_page_length` in 16: GLB words between consecutive tile rows.
- `if_tile_length` in 5: beats per row.
- `if_tile_height` in 5: rows per tile.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse on completion.
- `rd_en` out 1: GLB read strobe.
- `rd_addr` out 16: GLB read address.
- `rd_data` in 128: GLB read data, valid `RD_LATENCY` cycles after `rd_en`.
- `lb_valid` out 1: beat available to the LB.
- `lb_ready` in 1: LB accepts the beat.
- `lb_data` out 128: beat payload.
- `lb_last` out 1: qualifies the final beat of the tile.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE → FETCH when `start` is high and both tile dimensions are nonzero. Config is latched in this transition.
  - IDLE + `start` with `if_tile_length`==0 or `if_tile_height`==0: no reads are issued, `done` pulses the next cycle, and the FSM stays in IDLE.
  - FETCH → DRAIN once the last read is issued.
  - DRAIN → IDLE when the final beat is popped (`lb_valid`&`lb_ready`&`lb_last`). `done` pulses in that same cycle (registered, visible the next cycle).
- Counters `cnt_h` and `cnt_v` are 5 bits. `cnt_h` wraps at length−1 and increments `cnt_v`. The last read is issued at (height−1, length−1).
- Address: `rd_addr` = `if_base_addr` + `cnt_v`·`if_page_length` + `cnt_h`, computed modulo 2^16. Wrap-around is legal and produces no error.
- Issue rule: `rd_en` is asserted in FETCH only when `fifo_count` + `inflight` < `FIFO_DEPTH`.
  - The check is conservative: a pop in the same cycle does not free a credit until the next cycle.
  - `inflight` counts reads whose data has not yet returned.
- Return path: a valid pipe `RD_LATENCY` deep tracks `rd_en`. `rd_data` is pushed into the FIFO when the pipe output is high. The FIFO can never overflow.
- FIFO is first-word-fall-through: `lb_valid` = (`fifo_count`≠0), and `lb_data`/`lb_last` come from the head entry.
- `lb_last` is pushed as a tag alongside the data of the final read.
- `start` while `busy` is ignored.
- The LB may hold `lb_ready` low indefinitely. `lb_data` and `lb_last` stay stable while `lb_valid` is high and `lb_ready` is low.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `lb_valid`=0, `lb_data`=0, `lb_last`=0; FIFO, counters, valid pipe and `inflight` are all cleared.
- `start` accepted at cycle 0 → first `rd_en` at cycle 1 → first `lb_valid` at cycle 1+`RD_LATENCY`+1.
- With `lb_ready` held high and `FIFO_DEPTH` ≥ `RD_LATENCY`+2: one beat per cycle sustained, and total tile time is N + `RD_LATENCY` + 2 cycles from `start` to `done`, where N = length·height.
- `rd_addr` holds its last value when `rd_en` is low.
- Reset mid-operation: state returns to IDLE immediately. Returning `rd_data` from reads already issued is discarded because the valid pipe is cleared. No `done` is produced.

## Configuration
- `GLB2LB_PERF_CNT_EN` defined:
  - Adds output `stall_cycles` [15:0], which counts cycles with `lb_valid`&!`lb_ready` while `busy`.
  - The counter saturates at 0xFFFF and clears on an accepted `start` and on `rst`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `glb_pkg`:
  - widths `GLB_ADDR_W`=16, `GLB_DATA_W`=128, `TILE_DIM_W`=5;
  - FSM state enum (one-hot: IDLE='b001, FETCH='b010, DRAIN='b100).
- One sub-module, `glb2lb_fifo`:
  - parameterised FWFT FIFO (depth, width 129 = data + last);
  - exposes `count`, `push`, `pop`, `head`.
- Top level holds the FSM, counters, address generation, valid pipe and credit logic.

## Test plan
- Base 0x0100, page 0x0020, length 3, height 2, `lb_ready`=1, `RD_LATENCY`=1: addresses 0x100, 0x101, 0x102, 0x120, 0x121, 0x122; 6 beats in order; `lb_last` only on beat 6; `done` at cycle 9.
- Same tile with `lb_ready` low for cycles 3–10: `rd_en` stops after `FIFO_DEPTH` outstanding; no beat is lost or duplicated; data stays stable while stalled; with PERF enabled, `stall_cycles`=8.
- Base 0xFFFE, page 0x0010, length 4, height 1: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `if_tile_length`=0: no `rd_en`; `done` one cycle after `start`; `busy` stays 0.
- `rst` asserted after the 2nd beat of a 4×4 tile: all outputs go to reset values next cycle; a new `start` then fetches a full 16 beats correctly.
- `RD_LATENCY`=3, `FIFO_DEPTH`=5, 4×4 tile, ready always high: 16 beats back-to-back with no bubbles after the first.

Source files
------------

// File: rtl/glb_pkg.sv
// glb_pkg: shared widths and FSM encoding for the GLB-to-LB tile fetcher.
package glb_pkg;
  localparam int GLB_ADDR_W = 16;
  localparam int GLB_DATA_W = 128;
  localparam int TILE_DIM_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    FETCH = 3'b010,
    DRAIN = 3'b100
  } state_e;
endpackage

// File: rtl/glb2lb_fifo.sv
// glb2lb_fifo: first-word-fall-through skid FIFO.
// head_o is meaningful only while count_o is nonzero.
module glb2lb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 129,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i)  rd_q <= inc(rd_q);
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/glb_2_lb.sv
// glb_2_lb: streams a row-major GLB tile into the line buffer.
// Define GLB2LB_PERF_CNT_EN to add the stall_cycles counter output.
module glb_2_lb
  import glb_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [GLB_ADDR_W-1:0] if_base_addr,
  input  logic [GLB_ADDR_W-1:0] if_page_length,
  input  logic [TILE_DIM_W-1:0] if_tile_length,
  input  logic [TILE_DIM_W-1:0] if_tile_height,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [GLB_ADDR_W-1:0] rd_addr,
  input  logic [GLB_DATA_W-1:0] rd_data,
  output logic                  lb_valid,
  input  logic                  lb_ready,
  output logic [GLB_DATA_W-1:0] lb_data,
  output logic                  lb_last
`ifdef GLB2LB_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PADW = GLB_ADDR_W - TILE_DIM_W;

  state_e                state_q, state_d;
  logic [GLB_ADDR_W-1:0] base_q, page_q;
  logic [TILE_DIM_W-1:0] len_q, hgt_q;
  logic [TILE_DIM_W-1:0] cnt_h_q, cnt_h_d;
  logic [TILE_DIM_W-1:0] cnt_v_q, cnt_v_d;
  logic [RD_LATENCY-1:0] vld_q, tag_q;
  logic [CW-1:0]         infl_q, fifo_cnt;
  logic                  done_q, done_d;
  logic                  accept, nz, row_end, last_rd;
  logic                  push, pop, credit_ok;
  logic [GLB_DATA_W:0]   head;

  assign accept  = (state_q == IDLE) && start;
  assign nz      = (|if_tile_length) && (|if_tile_height);
  assign row_end = cnt_h_q == len_q - 1'b1;
  assign last_rd = row_end && (cnt_v_q == hgt_q - 1'b1);
  assign push    = vld_q[RD_LATENCY-1];
  assign pop     = lb_valid && lb_ready;
  // Pops free a credit only once fifo_cnt has actually dropped
  assign credit_ok =
    (32'(fifo_cnt) + 32'(infl_q)) < FIFO_DEPTH;

  always_comb begin
    state_d = state_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !nz) begin
          done_d = 1'b1;
        end else if (start) begin
          state_d = FETCH;
          cnt_h_d = '0;
          cnt_v_d = '0;
        end
      end
      FETCH: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (last_rd) begin
            state_d = DRAIN;
          end else if (row_end) begin
            cnt_h_d = '0;
            cnt_v_d = cnt_v_q + 1'b1;
          end else begin
            cnt_h_d = cnt_h_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && lb_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      base_q  <= '0;
      page_q  <= '0;
      len_q   <= '0;
      hgt_q   <= '0;
      vld_q   <= '0;
      tag_q   <= '0;
      infl_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      done_q  <= done_d;
      if (accept && nz) begin
        base_q <= if_base_addr;
        page_q <= if_page_length;
        len_q  <= if_tile_length;
        hgt_q  <= if_tile_height;
      end
      vld_q[0] <= rd_en;
      tag_q[0] <= rd_en && last_rd;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      if (rd_en && !push)
        infl_q <= infl_q + 1'b1;
      else if (!rd_en && push)
        infl_q <= infl_q - 1'b1;
    end
  end

  assign rd_addr = base_q
    + GLB_ADDR_W'({{PADW{1'b0}}, cnt_v_q} * page_q)
    + {{PADW{1'b0}}, cnt_h_q};

  glb2lb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (GLB_DATA_W + 1)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({tag_q[RD_LATENCY-1], rd_data}),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign lb_valid = fifo_cnt != '0;
  assign lb_last  = lb_valid && head[GLB_DATA_W];
  assign lb_data  = lb_valid ? head[GLB_DATA_W-1:0] : '0;
  assign busy     = state_q != IDLE;
  assign done     = done_q;

`ifdef GLB2LB_PERF_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (rst || accept)
      stall_q <= '0;
    else if (busy && lb_valid && !lb_ready
             && stall_q != 16'hFFFF)
      stall_q <= stall_q + 1'b1;
  end

  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_glb_2_lb.sv
// tb_glb_2_lb: two fetchers (latency 1/depth 4, latency 3/depth 5)
// share stimulus and are checked against a row-major tile model.
`timescale 1ns/1ps
module tb_glb_2_lb;
  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        lb_ready = 1'b1;
  logic [15:0] base = '0;
  logic [15:0] page = '0;
  logic [4:0]  tlen = '0;
  logic [4:0]  thgt = '0;

  logic         busy [2];
  logic         done [2];
  logic         rd_en [2];
  logic         lb_valid [2];
  logic         lb_last [2];
  logic [15:0]  rd_addr [2];
  logic [127:0] lb_data [2];
  logic [127:0] pipe [2][3];
`ifdef GLB2LB_PERF_CNT_EN
  logic [15:0]  stall [2];
`endif

  int ntest = 0;
  int nfail = 0;
  int cyc = 0;
  int t0 = 0;
  int nad [2];
  int nbt [2];
  int nbusy [2];
  int dcyc [2];
  int adc [2][64];
  int btc [2][64];
  logic [15:0]  adq [2][64];
  logic [128:0] btq [2][64];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int dep(input int g);
    return (g == 0) ? 4 : 5;
  endfunction

  function automatic logic [127:0] gdata(
    input logic [15:0] a
  );
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1111,
            a - 16'h0F0F, a ^ 16'hA5A5,
            {a[7:0], a[15:8]}, 16'hC0DE};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    glb_2_lb #(
      .RD_LATENCY (1 + 2 * g),
      .FIFO_DEPTH (4 + g)
    ) dut (
      .clock          (clock),
      .rst            (rst),
      .start          (start),
      .if_base_addr   (base),
      .if_page_length (page),
      .if_tile_length (tlen),
      .if_tile_height (thgt),
      .busy           (busy[g]),
      .done           (done[g]),
      .rd_en          (rd_en[g]),
      .rd_addr        (rd_addr[g]),
      .rd_data        (pipe[g][2*g]),
      .lb_valid       (lb_valid[g]),
      .lb_ready       (lb_ready),
      .lb_data        (lb_data[g]),
      .lb_last        (lb_last[g])
`ifdef GLB2LB_PERF_CNT_EN
      ,
      .stall_cycles   (stall[g])
`endif
    );
  end

  // GLB: data for a read appears lat(g) cycles later; junk otherwise
  always @(posedge clock)
    for (int g = 0; g < 2; g++) begin
      pipe[g][0] <= rd_en[g] ? gdata(rd_addr[g])
                             : {4{$urandom}};
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end

  always @(negedge clock)
    for (int g = 0; g < 2; g++) begin
      if (rd_en[g] && nad[g] < 64) begin
        adq[g][nad[g]] = rd_addr[g];
        adc[g][nad[g]] = cyc - t0;
        nad[g]++;
      end
      if (lb_valid[g] && lb_ready && nbt[g] < 64) begin
        btq[g][nbt[g]] = {lb_last[g], lb_data[g]};
        btc[g][nbt[g]] = cyc - t0;
        nbt[g]++;
      end
      if (done[g] && dcyc[g] < 0) dcyc[g] = cyc - t0;
      if (busy[g]) nbusy[g]++;
    end

  task automatic check(input string tag,
                       input logic [128:0] obs,
                       input logic [128:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear();
    for (int g = 0; g < 2; g++) begin
      nad[g] = 0;
      nbt[g] = 0;
      nbusy[g] = 0;
      dcyc[g] = -1;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_busy_g%0d", tag, g), busy[g], 0);
      check($sformatf("%s_done_g%0d", tag, g), done[g], 0);
      check($sformatf("%s_rden_g%0d", tag, g), rd_en[g], 0);
      check($sformatf("%s_addr_g%0d", tag, g), rd_addr[g], 0);
      check($sformatf("%s_vld_g%0d", tag, g), lb_valid[g], 0);
      check($sformatf("%s_data_g%0d", tag, g), lb_data[g], 0);
      check($sformatf("%s_last_g%0d", tag, g), lb_last[g], 0);
    end
  endtask

  function automatic logic rdy(input int mode, input int rel);
    if (mode == 0) return 1'b1;
    if (mode == 1) return !(rel >= 3 && rel <= 10);
    return $urandom_range(0, 3) != 0;
  endfunction

  // mode 0: ready high, 1: ready low in cycles 3..10, 2: random
  task automatic run_tile(input logic [15:0] b,
                          input logic [15:0] p,
                          input logic [4:0] l,
                          input logic [4:0] h,
                          input int mode);
    int n;
    int rel;
    int lo;
    logic [15:0] a;
    logic [128:0] hold [2];
    n = int'(l) * int'(h);
    clear();
    base = b;
    page = p;
    tlen = l;
    thgt = h;
    t0 = cyc;
    start = 1'b1;
    lb_ready = rdy(mode, 0);
    tick();
    start = 1'b0;
    rel = cyc - t0;
    while ((dcyc[0] < 0 || dcyc[1] < 0) && rel < 600) begin
      lb_ready = rdy(mode, rel);
      if (mode == 1)
        for (int g = 0; g < 2; g++) begin
          if (rel == lat(g) + 2)
            hold[g] = {lb_last[g], lb_data[g]};
          if (rel > lat(g) + 2 && rel <= 10) begin
            check($sformatf("stall_vld_c%0d_g%0d", rel, g),
                  lb_valid[g], 1);
            check($sformatf("stall_hold_c%0d_g%0d", rel, g),
                  {lb_last[g], lb_data[g]}, hold[g]);
          end
          if (rel == 11)
            check($sformatf("stall_issued_g%0d", g),
                  nad[g], dep(g));
        end
      tick();
      rel = cyc - t0;
    end
    lb_ready = 1'b1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("done_seen_g%0d", g), dcyc[g] >= 0, 1);
      check($sformatf("nreads_g%0d", g), nad[g], n);
      check($sformatf("nbeats_g%0d", g), nbt[g], n);
      for (int i = 0; i < n && i < 64; i++) begin
        a = b + 16'(i / int'(l)) * p + 16'(i % int'(l));
        check($sformatf("addr%0d_g%0d", i, g), adq[g][i], a);
        check($sformatf("beat%0d_g%0d", i, g), btq[g][i],
              {i == n - 1, gdata(a)});
      end
      if (mode == 0) begin
        check($sformatf("done_cyc_g%0d", g),
              dcyc[g], n + lat(g) + 2);
        check($sformatf("first_rd_g%0d", g), adc[g][0], 1);
        check($sformatf("first_vld_g%0d", g),
              btc[g][0], lat(g) + 2);
        check($sformatf("last_beat_cyc_g%0d", g),
              btc[g][n-1], lat(g) + 1 + n);
      end
`ifdef GLB2LB_PERF_CNT_EN
      if (mode == 1) begin
        lo = (lat(g) + 2 > 3) ? lat(g) + 2 : 3;
        check($sformatf("stall_cnt_g%0d", g),
              stall[g], 10 - lo + 1);
      end
`else
      lo = 0;
`endif
    end
  endtask

  initial begin
    int k;
    clear();
    rst = 1'b1;
    repeat (3) tick();
    check_reset("por");
    rst = 1'b0;
    tick();

    run_tile(16'h0100, 16'h0020, 5'd3, 5'd2, 0);
    run_tile(16'h0100, 16'h0020, 5'd3, 5'd2, 1);
    run_tile(16'hFFFE, 16'h0010, 5'd4, 5'd1, 0);

    // zero-sized tiles: immediate done, no reads, never busy
    for (int z = 0; z < 2; z++) begin
      clear();
      base = 16'h1234;
      page = 16'h0001;
      tlen = (z == 0) ? 5'd0 : 5'd3;
      thgt = (z == 0) ? 5'd3 : 5'd0;
      t0 = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      for (int g = 0; g < 2; g++) begin
        check($sformatf("zero%0d_done_g%0d", z, g), dcyc[g], 1);
        check($sformatf("zero%0d_rd_g%0d", z, g), nad[g], 0);
        check($sformatf("zero%0d_busy_g%0d", z, g), nbusy[g], 0);
      end
    end

    // reset after the second beat of a 4x4 tile
    clear();
    base = 16'h0200;
    page = 16'h0040;
    tlen = 5'd4;
    thgt = 5'd4;
    lb_ready = 1'b1;
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (nbt[0] < 2 && k < 50) begin
      tick();
      k++;
    end
    check("rst_trigger", nbt[0] >= 2, 1);
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    dcyc[0] = -1;
    dcyc[1] = -1;
    repeat (6) tick();
    for (int g = 0; g < 2; g++)
      check($sformatf("midrst_nodone_g%0d", g), dcyc[g], -1);
    run_tile(16'h0200, 16'h0040, 5'd4, 5'd4, 0);

    repeat (8)
      run_tile(16'($urandom), 16'($urandom),
               5'($urandom_range(1, 6)),
               5'($urandom_range(1, 4)), 2);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
